// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared definitions for the iterative 32x32 multiplier: FSM state
//            encoding and the iteration / latency constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Two multiplier bits retired per CALC cycle -> 16 iterations for 32 bits.
    localparam int MULT_ITERS   = 16;
    // Start edge to done_o: 16 CALC edges + 1 FIN edge.
    localparam int MULT_LATENCY = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_r4_pp.sv
`default_nettype none
// ============================================================================
// Module   : mult_r4_pp
// Purpose  : Combinational radix-4 partial-product select. Picks 0, ma, 2*ma
//            or 3*ma according to two multiplier bits.
// Ports    : ma_i   [31:0] multiplicand magnitude
//            ma3_i  [33:0] precomputed 3*ma
//            sel_i  [1:0]  current multiplier digit
//            pp_o   [33:0] selected partial product
// Revision : 1.0 - initial release
// ============================================================================
module mult_r4_pp (
    input  logic [31:0] ma_i,
    input  logic [33:0] ma3_i,
    input  logic [1:0]  sel_i,
    output logic [33:0] pp_o
);

    always_comb begin
        pp_o = 34'd0;
        case (sel_i)
            2'd0: pp_o = 34'd0;
            2'd1: pp_o = {2'b00, ma_i};
            2'd2: pp_o = {1'b0, ma_i, 1'b0};
            2'd3: pp_o = ma3_i;
            default: pp_o = 34'd0;
        endcase
    end

endmodule : mult_r4_pp
`default_nettype wire

// File: rtl/iter_mult.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult
// Purpose  : Iterative 32x32 -> 64 multiplier for the execute-stage ALU.
//            Radix-4 shift-add on operand magnitudes (2 bits per cycle), then
//            sign correction and optional HI/LO accumulate. Fixed latency of
//            17 cycles from the start edge to the done_o pulse.
// Macro    : MULT_ACC_EN - when defined, acc_i/acc_en_i/sub_i are latched at
//            start and applied in FIN (MADD/MSUB in-block). When undefined
//            those inputs are ignored and product_o is the plain product.
// Ports    : clk_i      clock
//            rst_i      synchronous active-high reset
//            flush_i    synchronous abort, same effect as reset
//            start_i    request, sampled only in IDLE
//            signed_i   1 = two's-complement operands
//            a_i, b_i   [31:0] multiplicand / multiplier
//            acc_i      [63:0] {hi, lo} accumulator (MULT_ACC_EN only)
//            acc_en_i   accumulate enable (MULT_ACC_EN only)
//            sub_i      1 = acc - product, 0 = acc + product
//            busy_o     state != IDLE
//            done_o     one-cycle pulse when product_o updates
//            product_o  [63:0] result, held until next done/flush/reset
// Revision : 1.0 - initial release
// ============================================================================
module iter_mult
    import mult_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] acc_i,
    input  logic        acc_en_i,
    input  logic        sub_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] product_o
);

    mult_state_t state_q, state_d;
    logic [31:0] ma_q,      ma_d;
    logic [33:0] ma3_q,     ma3_d;
    logic [31:0] mb_q,      mb_d;
    logic        neg_q,     neg_d;
    logic [63:0] sum_q,     sum_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic        done_q,    done_d;
    logic [63:0] product_q, product_d;

    logic [31:0] abs_a, abs_b;
    logic [33:0] pp;
    logic [63:0] mag;
    logic [63:0] result;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned
    // magnitude, so no extra bit is needed.
    assign abs_a = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign abs_b = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

    mult_r4_pp u_pp (
        .ma_i  (ma_q),
        .ma3_i (ma3_q),
        .sel_i (mb_q[1:0]),
        .pp_o  (pp)
    );

    assign mag = neg_q ? (64'd0 - sum_q) : sum_q;

`ifdef MULT_ACC_EN
    logic [63:0] acc_q,    acc_d;
    logic        acc_en_q, acc_en_d;
    logic        sub_q,    sub_d;

    assign result = acc_en_q ? (sub_q ? (acc_q - mag) : (acc_q + mag)) : mag;
`else
    // Accumulate inputs are intentionally ignored in this build.
    logic unused_acc;
    assign unused_acc = ^{acc_i, acc_en_i, sub_i};
    assign result     = mag;
`endif

    always_comb begin
        state_d   = state_q;
        ma_d      = ma_q;
        ma3_d     = ma3_q;
        mb_d      = mb_q;
        neg_d     = neg_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;
`ifdef MULT_ACC_EN
        acc_d     = acc_q;
        acc_en_d  = acc_en_q;
        sub_d     = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ma_d    = abs_a;
                    ma3_d   = {2'b00, abs_a} + {1'b0, abs_a, 1'b0};
                    mb_d    = abs_b;
                    neg_d   = signed_i & (a_i[31] ^ b_i[31]);
                    sum_d   = 64'd0;
                    cnt_d   = 4'd0;
`ifdef MULT_ACC_EN
                    acc_d    = acc_i;
                    acc_en_d = acc_en_i;
                    sub_d    = sub_i;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                // Digit cnt carries weight 4^cnt.
                sum_d = sum_q + ({30'd0, pp} << {cnt_q, 1'b0});
                mb_d  = mb_q >> 2;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(MULT_ITERS - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                product_d = result;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q   <= IDLE;
            ma_q      <= 32'd0;
            ma3_q     <= 34'd0;
            mb_q      <= 32'd0;
            neg_q     <= 1'b0;
            sum_q     <= 64'd0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            product_q <= 64'd0;
`ifdef MULT_ACC_EN
            acc_q     <= 64'd0;
            acc_en_q  <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ma_q      <= ma_d;
            ma3_q     <= ma3_d;
            mb_q      <= mb_d;
            neg_q     <= neg_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
`ifdef MULT_ACC_EN
            acc_q     <= acc_d;
            acc_en_q  <= acc_en_d;
            sub_q     <= sub_d;
`endif
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule : iter_mult
`default_nettype wire

// File: tb/tb_iter_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_mult
// Purpose  : Directed self-checking bench for iter_mult: latency, signed and
//            unsigned corners, accumulate, flush, reset in FIN, start while
//            busy and start held through the done cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_mult;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [63:0] acc_i;
    logic        acc_en_i;
    logic        sub_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] product_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    iter_mult dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .acc_i     (acc_i),
        .acc_en_i  (acc_en_i),
        .sub_i     (sub_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble operands after the start edge, and wait
    // for done_o. Returns positioned 1 time unit after the done edge.
    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] acc,
                         input logic aen, input logic sb, input logic [63:0] exp);
        int n;
        int busy_cnt;
        @(negedge clk_i);
        signed_i = sgn; a_i = a; b_i = b; acc_i = acc; acc_en_i = aen; sub_i = sb;
        start_i  = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678; acc_i = 64'h5555; sub_i = ~sb;
        n = 0; busy_cnt = 0;
        while (!done_o && n < 40) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd17);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd17);
        chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
        chk({tag, "_product"}, product_o, exp);
    endtask

    initial begin
        int n;
        int dones;
        int first_at;
        int second_at;
        logic [63:0] p1, p2;

        rst_i = 1'b1; flush_i = 1'b0; start_i = 1'b0; signed_i = 1'b0;
        a_i = '0; b_i = '0; acc_i = '0; acc_en_i = 1'b0; sub_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_product", product_o, 64'd0);
        @(negedge clk_i); rst_i = 1'b0;

        // Unsigned and signed corners
        do_op("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk_i); #1;
        chk("done_pulse_width", 64'(done_o), 64'd0);
        chk("product_held", product_o, 64'hFFFF_FFFE_0000_0001);
        do_op("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'd0, 1'b0, 1'b0, 64'h4000_0000_0000_0000);
        do_op("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'd1);
        do_op("s_maxxm1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_8000_0001);
        do_op("u_minx2", 1'b0, 32'h8000_0000, 32'd2, 64'd0, 1'b0, 1'b0, 64'h0000_0001_0000_0000);
        do_op("u_x16", 1'b0, 32'h1234_5678, 32'h10, 64'd0, 1'b0, 1'b0, 64'h0000_0001_2345_6780);

        // Accumulate
`ifdef MULT_ACC_EN
        do_op("acc_add", 1'b0, 32'd2, 32'd3, 64'd1, 1'b1, 1'b0, 64'd7);
        do_op("acc_sub", 1'b0, 32'd1, 32'd1, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        do_op("acc_add", 1'b0, 32'd2, 32'd3, 64'd1, 1'b1, 1'b0, 64'd6);
        do_op("acc_sub", 1'b0, 32'd1, 32'd1, 64'd0, 1'b1, 1'b1, 64'd1);
`endif

        // Flush on the 8th CALC cycle (sampled at E9)
        @(negedge clk_i);
        signed_i = 1'b0; a_i = 32'd100; b_i = 32'd200; acc_en_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (8) @(posedge clk_i);
        @(negedge clk_i); flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_product", product_o, 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("flush_no_done", 64'(dones), 64'd0);
        do_op("after_flush", 1'b0, 32'd100, 32'd200, 64'd0, 1'b0, 1'b0, 64'd20000);

        // start_i pulsed while busy is ignored
        @(negedge clk_i);
        signed_i = 1'b0; a_i = 32'd7; b_i = 32'd6; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i); a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("busy_start_dones", 64'(dones), 64'd1);
        chk("busy_start_product", product_o, 64'd42);

        // start_i held through the done cycle -> second op accepted there
        @(negedge clk_i);
        signed_i = 1'b0; a_i = 32'd5; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1;
        n = 0; dones = 0; first_at = -1; second_at = -1; p1 = '0; p2 = '0;
        while (n < 60 && dones < 2) begin
            @(posedge clk_i); #1;
            n++;
            if (done_o) begin
                dones++;
                if (dones == 1) begin first_at = n; p1 = product_o; end
                else begin second_at = n; p2 = product_o; end
            end
            if (n == 17) begin a_i = 32'd11; b_i = 32'd13; end
            if (n == 18) start_i = 1'b0;
        end
        start_i = 1'b0;
        chk("held_first_at", 64'(first_at), 64'd17);
        chk("held_first_product", p1, 64'd25);
        chk("held_second_at", 64'(second_at), 64'd35);
        chk("held_second_product", p2, 64'd143);
        @(posedge clk_i); #1;

        // Reset asserted while in FIN
        @(negedge clk_i);
        signed_i = 1'b0; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (16) @(posedge clk_i);
        #1; rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_fin_busy", 64'(busy_o), 64'd0);
        chk("rst_fin_done", 64'(done_o), 64'd0);
        chk("rst_fin_product", product_o, 64'd0);
        @(negedge clk_i); rst_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("rst_fin_no_done", 64'(dones), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iter_mult
`default_nettype wire
